// File: rtl/wb_slave_mux_if.sv
// wb_slave_mux_if: upstream Wishbone and per-slave fan-out signals of wb_slave_mux (WB_MUX_ERR_LOG_EN adds error-log outputs)
interface wb_slave_mux_if #(
  parameter int NUM_SLV = 4
);
  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_adr_i;
  logic [31:0]            wbs_dat_i;
  logic                   wbs_ack_o;
  logic [31:0]            wbs_dat_o;
  logic [NUM_SLV-1:0]     s_cyc_o;
  logic [NUM_SLV-1:0]     s_stb_o;
  logic                   s_we_o;
  logic [3:0]             s_sel_o;
  logic [31:0]            s_adr_o;
  logic [31:0]            s_dat_o;
  logic [NUM_SLV-1:0]     s_ack_i;
  logic [NUM_SLV*32-1:0]  s_dat_i;
  logic                   err_o;
`ifdef WB_MUX_ERR_LOG_EN
  logic [31:0]            err_adr_o;
  logic [1:0]             err_cause_o;
  logic                   err_irq_o;
`endif
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, s_ack_i, s_dat_i,
`ifdef WB_MUX_ERR_LOG_EN
    output err_adr_o, err_cause_o, err_irq_o,
`endif
    output wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, s_ack_i, s_dat_i,
`ifdef WB_MUX_ERR_LOG_EN
    input  err_adr_o, err_cause_o, err_irq_o,
`endif
    input  wbs_ack_o, wbs_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, err_o
  );
endinterface

// File: rtl/wb_slave_mux.sv
// wb_slave_mux: Wishbone classic 1-to-NUM_SLV slave mux with ack timeout and unmapped-address error (WB_MUX_ERR_LOG_EN adds error log + irq)
module wb_slave_mux #(
  parameter int                    NUM_SLV     = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {32'h2800_0000, 32'h2000_0000, 32'h3800_0000, 32'h3000_0000},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {NUM_SLV{32'hFF00_0000}},
  parameter int                    TIMEOUT_CYC = 255,
  parameter logic [31:0]           ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  wb_slave_mux_if.slave bus
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, BUSY, ERR, DONE} state_t;
  state_t             state, state_nxt;
  logic [IW-1:0]      idx, idx_nxt, hit_idx;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               hit, req, clr, ack_sel, tmo, take;
  logic               ack_q, ack_nxt, err_q, err_nxt;
  logic [31:0]        dat_q, dat_nxt;
  logic [NUM_SLV-1:0] stb_q, stb_nxt;
  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        adr_q, wdat_q;
  assign req     = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign ack_sel = bus.s_ack_i[idx];
  assign tmo     = cnt == CW'(TIMEOUT_CYC - 1);
  assign take    = state == BUSY && bus.wbs_cyc_i && ack_sel;
`ifdef WB_MUX_ERR_LOG_EN
  assign clr = req && bus.wbs_we_i && bus.wbs_adr_i == SLV_BASE[31:0] + 32'h00FF_FFFC;
`else
  assign clr = 1'b0;
`endif
  // address decode; scanning downwards lets the lowest matching window win
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((bus.wbs_adr_i & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
  end
  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_nxt;
  // next state: master abort beats slave ack, slave ack beats timeout
  always_comb begin
    state_nxt = state == IDLE ? (!req ? IDLE : clr ? DONE : hit ? BUSY : ERR)
              : state == BUSY ? (!bus.wbs_cyc_i ? IDLE : ack_sel ? DONE : tmo ? ERR : BUSY)
              : state == ERR  ? DONE : IDLE;
  end
  // next values of the registered outputs and datapath
  always_comb begin
    idx_nxt = state == IDLE && req ? hit_idx : idx;
    stb_nxt = state_nxt == BUSY ? NUM_SLV'(1) << idx_nxt : '0;
    cnt_nxt = state == BUSY && state_nxt == BUSY ? cnt + 1'b1 : '0;
    ack_nxt = take || state == ERR || (state == IDLE && clr);
    err_nxt = state == ERR;
    dat_nxt = state == ERR ? ERR_DATA : take ? bus.s_dat_i[32*idx +: 32] : dat_q;
  end
  // registered response path and request copy towards the slaves
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      idx    <= '0;
      cnt    <= '0;
      stb_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      wdat_q <= '0;
    end else begin
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      stb_q <= stb_nxt;
      ack_q <= ack_nxt;
      err_q <= err_nxt;
      dat_q <= dat_nxt;
      if (state == IDLE && req && !clr) begin
        we_q   <= bus.wbs_we_i;
        sel_q  <= bus.wbs_sel_i;
        adr_q  <= bus.wbs_adr_i;
        wdat_q <= bus.wbs_dat_i;
      end
    end
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.s_cyc_o   = stb_q;
  assign bus.s_stb_o   = stb_q;
  assign bus.s_we_o    = we_q;
  assign bus.s_sel_o   = sel_q;
  assign bus.s_adr_o   = adr_q;
  assign bus.s_dat_o   = wdat_q;
  assign bus.err_o     = err_q;
`ifdef WB_MUX_ERR_LOG_EN
  logic        logged, irq, miss_ev, tmo_ev;
  logic [31:0] eadr;
  logic [1:0]  ecause;
  assign miss_ev = state == IDLE && req && !clr && !hit;
  assign tmo_ev  = state == BUSY && bus.wbs_cyc_i && !ack_sel && tmo;
  // first error is logged and held; irq stays up until the clear write
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      logged <= 1'b0;
      irq    <= 1'b0;
      eadr   <= '0;
      ecause <= '0;
    end else begin
      if ((miss_ev || tmo_ev) && !logged) begin
        logged <= 1'b1;
        eadr   <= miss_ev ? bus.wbs_adr_i : adr_q;
        ecause <= miss_ev ? 2'b01 : 2'b10;
      end
      irq <= miss_ev || tmo_ev || (irq && !(state == IDLE && clr));
    end
  assign bus.err_adr_o   = eadr;
  assign bus.err_cause_o = ecause;
  assign bus.err_irq_o   = irq;
`endif
endmodule

// File: tb/tb_wb_slave_mux.sv
// tb_wb_slave_mux: directed scoreboard bench for wb_slave_mux
module tb_wb_slave_mux;
  localparam int N = 4;
  typedef struct {logic [31:0] dat; logic err;} exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  int           nchk = 0;
  int           nerr = 0;
  logic [31:0]  rdat [N];
  int           lat [N];
  logic [N-1:0] stray = '0;
  exp_t         sbq[$];
  wb_slave_mux_if #(.NUM_SLV(N)) bus();
  wb_slave_mux #(
    .NUM_SLV(N),
    .SLV_BASE({32'h4000_0000, 32'h2000_0000, 32'h3800_0000, 32'h3000_0000}),
    .SLV_MASK({32'hFF00_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000}),
    .TIMEOUT_CYC(16),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.s_dat_i = {rdat[3], rdat[2], rdat[1], rdat[0]};
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  // slave models: slave i acks in its lat[i]-th strobe cycle (0 = never); stray slaves ack whenever any strobe is up
  initial begin
    int n [N];
    foreach (n[i]) n[i] = 0;
    bus.s_ack_i = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        n[i] = bus.s_stb_o[i] ? n[i] + 1 : 0;
        bus.s_ack_i[i] = (bus.s_stb_o[i] && lat[i] != 0 && n[i] == lat[i]) || (stray[i] && |bus.s_stb_o);
      end
    end
  end
  // monitor: every ack pops one expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        if (sbq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_ack: got ack with dat %h, expected no ack", bus.wbs_dat_o);
        end else begin
          e = sbq.pop_front();
          chk("ack_dat", bus.wbs_dat_o, e.dat);
          chk("ack_err", 32'(bus.err_o), 32'(e.err));
        end
      end else chk("err_without_ack", 32'(bus.err_o), 32'h0);
    end
  end
  task automatic xfer(input string nm, input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] edat, input logic eerr, input int ek, input logic [N-1:0] emask, input int ecnt);
    int k = 0;
    int c = 0;
    logic [N-1:0] seen = '0;
    sbq.push_back('{edat, eerr});
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = w;
    bus.wbs_adr_i = a;
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = s;
    do begin
      @(posedge clk);
      #1;
      k++;
      seen |= bus.s_stb_o;
      if (|bus.s_stb_o) c++;
    end while (!bus.wbs_ack_o && k < 200);
    chk({nm, "_latency"}, 32'(k), 32'(ek));
    chk({nm, "_stb_mask"}, 32'(seen), 32'(emask));
    chk({nm, "_stb_cycles"}, 32'(c), 32'(ecnt));
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    foreach (rdat[i]) rdat[i] = '0;
    #1 rst_n = 1'b0;
    idle(3);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_cyc_stb", 32'({bus.s_cyc_o, bus.s_stb_o}), 32'h0);
    chk("rst_sadr", bus.s_adr_o, 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);
`ifdef WB_MUX_ERR_LOG_EN
    chk("rst_irq", 32'(bus.err_irq_o), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rdat[0] = 32'h1234_5678;
    lat[0]  = 1;
    xfer("rd_s0", 32'h3000_0004, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2, 4'b0001, 1);
    idle(1);
    rdat[1] = 32'h1111_1111;
    lat[1]  = 5;
    xfer("wr_s1", 32'h3800_0010, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h1111_1111, 1'b0, 6, 4'b0010, 5);
    chk("wr_s_adr", bus.s_adr_o, 32'h3800_0010);
    chk("wr_s_dat", bus.s_dat_o, 32'hA5A5_A5A5);
    chk("wr_s_sel", 32'(bus.s_sel_o), 32'hF);
    chk("wr_s_we", 32'(bus.s_we_o), 32'h1);
    xfer("rd_gap", 32'h3000_0004, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 3, 4'b0001, 1);
    idle(1);
    xfer("rd_unmap", 32'h5000_0000, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 2, 4'b0000, 0);
    idle(1);
    xfer("wr_unmap", 32'h6000_0000, 1'b1, 32'h0102_0304, 4'h3, 32'hDEAD_BEEF, 1'b1, 2, 4'b0000, 0);
    chk("unmap_s_adr", bus.s_adr_o, 32'h6000_0000);
    idle(1);
    xfer("tmo_s2", 32'h2000_0040, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 18, 4'b0100, 16);
    idle(1);
`ifdef WB_MUX_ERR_LOG_EN
    chk("log_cause", 32'(bus.err_cause_o), 32'h1);
    chk("log_adr", bus.err_adr_o, 32'h5000_0000);
    chk("log_irq_set", 32'(bus.err_irq_o), 32'h1);
    xfer("irq_clr", 32'h30FF_FFFC, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1, 4'b0000, 0);
    chk("log_irq_clr", 32'(bus.err_irq_o), 32'h0);
    chk("log_cause_held", 32'(bus.err_cause_o), 32'h1);
`else
    xfer("rd_s0_top", 32'h30FF_FFFC, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2, 4'b0001, 1);
`endif
    idle(1);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_adr_i = 32'h2000_0000;
    idle(3);
    chk("abort_stb_busy", 32'(bus.s_stb_o), 32'h4);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    idle(1);
    chk("abort_stb_drop", 32'(bus.s_stb_o), 32'h0);
    idle(20);
    chk("abort_no_ack", 32'(bus.wbs_ack_o), 32'h0);
    lat[1] = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'h5;
    bus.wbs_adr_i = 32'h3800_0020;
    bus.wbs_dat_i = 32'hCAFE_0001;
    idle(2);
    chk("rstmid_stb_busy", 32'(bus.s_stb_o), 32'h2);
    #2;
    rst_n = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    #1;
    chk("rstmid_cyc_stb", 32'({bus.s_cyc_o, bus.s_stb_o}), 32'h0);
    chk("rstmid_sadr", bus.s_adr_o, 32'h0);
    chk("rstmid_sdat", bus.s_dat_o, 32'h0);
    chk("rstmid_ssel_we", 32'({bus.s_sel_o, bus.s_we_o}), 32'h0);
    chk("rstmid_dat", bus.wbs_dat_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    xfer("rd_after_rst", 32'h3000_0004, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2, 4'b0001, 1);
    idle(1);
    rdat[0]  = 32'h0BAD_0BAD;
    rdat[3]  = 32'h3333_3333;
    lat[3]   = 2;
    stray[0] = 1'b1;
    xfer("rd_s3_stray", 32'h4000_0100, 1'b0, 32'h0, 4'hF, 32'h3333_3333, 1'b0, 3, 4'b1000, 2);
    idle(3);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
